inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH_LOG, default 3, giving the instruction-queue depth as 2^QUEUE_DEPTH_LOG entries.
REQ-002 SHALL have parameter RESET_PC, default 32'h0, giving the first fetch address after reset.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rdy_in, input, 1 bit: global enable; while low, all state is frozen.
REQ-006 SHALL have port ic_req, output, 1 bit: one-cycle fetch-request pulse to the memory/icache.
REQ-007 SHALL have port ic_addr, output, 32 bits: fetch address, valid while ic_req is high.
REQ-008 SHALL have port ic_valid, input, 1 bit: response strobe for the single outstanding request.
REQ-009 SHALL have port ic_data, input, 32 bits: instruction word, valid while ic_valid is high.
REQ-010 SHALL have port if_valid, output, 1 bit: the queue head holds an instruction for the decoder.
REQ-011 SHALL have port if_inst, output, 32 bits: instruction word at the queue head.
REQ-012 SHALL have port if_pc, output, 32 bits: PC of the instruction at the queue head.
REQ-013 SHALL have port de_ready, input, 1 bit: the decoder accepts the head this cycle.
REQ-014 SHALL have port flush_in, input, 1 bit: redirect request from branch/jump resolution.
REQ-015 SHALL have port flush_pc, input, 32 bits: redirect target, sampled when flush_in is high.

Function
REQ-016 SHALL implement a circular queue of {pc, inst} entries with head pointer, tail pointer and a count of width QUEUE_DEPTH_LOG+1; pointers wrap modulo 2^QUEUE_DEPTH_LOG.
REQ-017 SHALL drive if_valid = (count != 0) and drive if_inst/if_pc from the head entry registers, with no combinational bypass from ic_data.
REQ-018 SHALL pop the head when if_valid && de_ready && rdy_in are all high.
REQ-019 SHALL implement the fetch FSM with states IDLE, WAIT and DROP, allowing at most one outstanding request.
REQ-020 SHALL, in IDLE with count < 2^QUEUE_DEPTH_LOG and no flush, pulse ic_req with ic_addr = fetch_pc and move to WAIT.
REQ-021 SHALL, in WAIT on ic_valid, push {fetch_pc, ic_data}, set fetch_pc to the next PC (REQ-030), and return to IDLE.
REQ-022 SHALL, in DROP on ic_valid, discard the response and return to IDLE.
REQ-023 SHALL give a latency of 1 cycle from ic_valid to if_valid when the queue was empty, and a minimum of 2 cycles between consecutive ic_req pulses.
REQ-024 SHALL, on a simultaneous push and pop, leave count unchanged; the REQ-020 issue rule guarantees a push never overflows.
REQ-025 SHALL, on flush_in (priority over push and pop), clear the queue (count=0, head=tail) and set fetch_pc = flush_pc.
REQ-026 SHALL, on a flush, move to DROP if in WAIT without ic_valid in the same cycle, stay in DROP if already in DROP, and otherwise go to IDLE.
REQ-027 SHALL, on a flush coinciding with ic_valid in WAIT, discard the response and go to IDLE.
REQ-028 SHALL issue no ic_req in the flush cycle itself.
REQ-029 SHALL, while rdy_in is low, hold all registers and force ic_req=0; the environment guarantees ic_valid=0 while rdy_in is low.
REQ-030 SHALL compute the next PC as fetch_pc+4 with 32-bit wrap-around (32'hFFFFFFFC wraps to 32'h0), except as stated in REQ-034.

Reset
REQ-031 SHALL, while rst_in is high at a clock edge, set: state=IDLE, count=0, head=tail=0, fetch_pc=RESET_PC, ic_req=0, ic_addr=0, if_valid=0, if_inst=0, if_pc=0.
REQ-032 SHALL abandon any outstanding request on reset mid-operation; memory is reset by the same rst_in.
REQ-033 SHALL give rst_in priority over flush_in and rdy_in.

Configuration
REQ-034 SHALL, with IF_PREDECODE_JAL_EN defined, compute the next PC for a pushed word whose opcode is 7'h6f as fetch_pc + sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, mod 2^32.
REQ-035 SHALL, without IF_PREDECODE_JAL_EN, fetch sequentially per REQ-030, with no opcode inspection logic present.

Verification
REQ-036 Reset with RESET_PC=0, memory returns ic_data = addr+32'h13 after 2 cycles, de_ready=1 -> ic_addr sequence 0,4,8; if_pc 0,4,8 in order; if_valid first high 1 cycle after the first ic_valid.
REQ-037 With de_ready=0 and depth 8 -> exactly 8 ic_req pulses, count=8, no further ic_req; raise de_ready -> one pop per cycle and fetching resumes.
REQ-038 With flush_in=1, flush_pc=32'h100 while in WAIT, then the stale ic_valid arrives -> stale word not queued; next ic_addr=32'h100; if_valid=0 until the 32'h100 word returns.
REQ-039 Flush in the same cycle as ic_valid and a pop -> queue empty, next ic_addr=flush_pc, count=0.
REQ-040 rdy_in=0 for 5 cycles mid-stream -> no ic_req, count/if_pc unchanged; stream resumes identically afterwards.
REQ-041 With IF_PREDECODE_JAL_EN, word 32'h0100006F (jal x0,+16) fetched at 32'h20 -> next ic_addr=32'h30; without the macro -> 32'h24.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit: issues single-outstanding fetch requests to the
// memory/icache, buffers returned words together with their PCs in a circular
// queue, and presents the queue head to the decoder. A flush from branch/jump
// resolution empties the queue, redirects the fetch PC and discards any
// response that belongs to a request issued before the flush.
//
// Optional build macro:
//   IF_PREDECODE_JAL_EN - when defined, a pushed word whose opcode is 7'h6f
//                         (JAL) redirects the next fetch to its jump target
//                         instead of fetch_pc+4. Undefined: purely
//                         sequential fetch, no opcode inspection.
//
// Parameters:
//   QUEUE_DEPTH_LOG - queue depth is 2**QUEUE_DEPTH_LOG entries
//   RESET_PC        - first fetch address after reset
//
// Ports:
//   clk_in    in   clock, rising edge
//   rst_in    in   synchronous active-high reset (priority over all)
//   rdy_in    in   global enable; low freezes every register
//   ic_req    out  one-cycle fetch request pulse
//   ic_addr   out  fetch address (zero when ic_req is low)
//   ic_valid  in   response strobe for the outstanding request
//   ic_data   in   returned instruction word
//   if_valid  out  queue head holds an instruction
//   if_inst   out  instruction at queue head
//   if_pc     out  PC of instruction at queue head
//   de_ready  in   decoder accepts the head this cycle
//   flush_in  in   redirect request
//   flush_pc  in   redirect target
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int          QUEUE_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_data,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        de_ready,
    input  logic        flush_in,
    input  logic [31:0] flush_pc
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
    localparam int PTR_W = QUEUE_DEPTH_LOG;
    localparam int CNT_W = QUEUE_DEPTH_LOG + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        fetch_pc_q;
    logic [31:0]        pc_mem_q   [DEPTH];
    logic [31:0]        inst_mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic [31:0]        next_pc;

    // ---------------------------------------------------------------- next PC
`ifdef IF_PREDECODE_JAL_EN
    logic [31:0] jal_imm;
    assign jal_imm = {{11{ic_data[31]}}, ic_data[31], ic_data[19:12],
                      ic_data[20], ic_data[30:21], 1'b0};
    assign next_pc = (ic_data[6:0] == 7'h6f) ? fetch_pc_q + jal_imm
                                              : fetch_pc_q + 32'd4;
`else
    assign next_pc = fetch_pc_q + 32'd4;
`endif

    // ---------------------------------------------------------- fetch FSM
    always_comb begin
        state_d = state_q;
        ic_req  = 1'b0;
        push    = 1'b0;
        if (!rst_in && rdy_in) begin
            if (flush_in) begin
                // A response still in flight belongs to the old path; park in
                // DROP until it arrives. If it arrives in this very cycle it
                // is consumed here, so there is nothing left to wait for.
                case (state_q)
                    WAIT:    state_d = ic_valid ? IDLE : DROP;
                    DROP:    state_d = ic_valid ? IDLE : DROP;
                    default: state_d = IDLE;
                endcase
            end else begin
                case (state_q)
                    IDLE: begin
                        // Issuing only with a free slot guarantees the
                        // eventual push cannot overflow the queue.
                        if (count_q != FULL_CNT) begin
                            ic_req  = 1'b1;
                            state_d = WAIT;
                        end
                    end
                    WAIT: begin
                        if (ic_valid) begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    DROP: begin
                        if (ic_valid) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign ic_addr  = ic_req ? fetch_pc_q : 32'h0;
    assign if_valid = (count_q != '0);
    assign if_inst  = inst_mem_q[head_q];
    assign if_pc    = pc_mem_q[head_q];
    assign pop      = if_valid && de_ready && rdy_in && !flush_in;

    // --------------------------------------------------------- state update
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (rdy_in) begin
            state_q <= state_d;
            if (flush_in) begin
                count_q    <= '0;
                tail_q     <= head_q;
                fetch_pc_q <= flush_pc;
            end else begin
                if (push) begin
                    pc_mem_q[tail_q]   <= fetch_pc_q;
                    inst_mem_q[tail_q] <= ic_data;
                    tail_q             <= tail_q + 1'b1;
                    fetch_pc_q         <= next_pc;
                end
                if (pop) begin
                    head_q <= head_q + 1'b1;
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A small memory model answers each
// request after a programmable latency with addr+32'h13 (or a special word at
// one chosen address). A queue-based reference model tracks what the decoder
// should see and what should be fetched next; every cycle the DUT outputs are
// compared with it. A directed vector table and hand-written sequences cover
// the reset-to-first-fetch timing, queue full, flushes, freeze and wrap cases,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, ic_req, ic_valid, if_valid, de_ready, flush_in;
    logic [31:0] ic_addr, ic_data, if_inst, if_pc, flush_pc;

    always #5 clk = ~clk;

    inst_fetch #(.QUEUE_DEPTH_LOG(3), .RESET_PC(32'h0)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_valid(ic_valid), .ic_data(ic_data),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .de_ready(de_ready), .flush_in(flush_in), .flush_pc(flush_pc)
    );

    int checks = 0;
    int passed = 0;

    // reference model
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_pending, m_stale;

    // memory model
    bit          mem_busy;
    int          mem_wait;
    int          mem_lat = 2;
    logic [31:0] mem_addr;
    logic [31:0] special_addr = 32'h1;
    logic [31:0] special_data = 32'h0;

    // last sampled outputs
    logic        s_req, s_ifv;
    logic [31:0] s_addr, s_ifpc, s_ifinst;

    typedef struct {
        logic        rdy, de, fl;
        logic [31:0] fpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ifpc;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == special_addr) return special_data;
        return a + 32'h13;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
`ifdef IF_PREDECODE_JAL_EN
        logic signed [19:0] imm20;
        if (w[6:0] == 7'h6f) begin
            imm20 = {w[31], w[19:12], w[20], w[30:21]};
            return pc + 32'(int'(imm20) * 2);
        end
`endif
        return pc + 32'd4;
    endfunction

    // One clock cycle: drive inputs, sample at negedge, compare with model,
    // advance model and memory, return #1 after the next posedge.
    task automatic cycle(input logic rst, input logic rdy, input logic de,
                         input logic fl, input logic [31:0] fpc);
        bit exp_req;
        rst_in = rst; rdy_in = rdy; de_ready = de; flush_in = fl; flush_pc = fpc;
        if (!rst && rdy && mem_busy && mem_wait == 0) begin
            ic_valid = 1'b1; ic_data = mem_word(mem_addr);
        end else begin
            ic_valid = 1'b0; ic_data = 32'h0;
        end
        @(negedge clk);
        s_req = ic_req; s_addr = ic_addr; s_ifv = if_valid;
        s_ifpc = if_pc; s_ifinst = if_inst;

        exp_req = !rst && rdy && !fl && !m_pending && (mq.size() < DEPTH);
        chk("ic_req", {31'b0, s_req}, {31'b0, exp_req});
        if (exp_req) chk("ic_addr", s_addr, m_pc);
        else         chk("ic_addr_idle", s_addr, 32'h0);
        chk("if_valid", {31'b0, s_ifv}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("if_pc", s_ifpc, mq[0].pc);
            chk("if_inst", s_ifinst, mq[0].inst);
        end

        if (rst) begin
            mq.delete(); m_pc = 32'h0; m_pending = 0; m_stale = 0;
        end else if (rdy) begin
            if (fl) begin
                mq.delete(); m_pc = fpc;
                if (ic_valid) begin m_pending = 0; m_stale = 0; end
                else if (m_pending) m_stale = 1;
            end else begin
                if (mq.size() != 0 && de) begin
                    $display("pop pc=%08h inst=%08h", mq[0].pc, mq[0].inst);
                    void'(mq.pop_front());
                end
                if (ic_valid) begin
                    if (!m_stale) begin
                        mq.push_back('{pc: m_pc, inst: ic_data});
                        m_pc = model_next(m_pc, ic_data);
                    end
                    m_pending = 0; m_stale = 0;
                end
                if (exp_req) m_pending = 1;
            end
        end

        if (rst || ic_valid) mem_busy = 0;
        else if (rdy && mem_busy && mem_wait != 0) mem_wait--;
        if (s_req && !rst) begin
            mem_busy = 1; mem_addr = s_addr; mem_wait = mem_lat - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 1, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 32'h0);
        chk("rst_ic_req", {31'b0, s_req}, 32'h0);
        chk("rst_ic_addr", s_addr, 32'h0);
        chk("rst_if_valid", {31'b0, s_ifv}, 32'h0);
        chk("rst_if_pc", s_ifpc, 32'h0);
        chk("rst_if_inst", s_ifinst, 32'h0);
    endtask

    initial begin : main
        int          reqs;
        bit          found;
        logic [31:0] exp_seq, tmp;
        logic [31:0] got_addr[3];
        logic [31:0] wrap_exp[3];

        rst_in = 1; rdy_in = 1; de_ready = 0; flush_in = 0; flush_pc = 0;
        ic_valid = 0; ic_data = 0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete(); m_pc = 0; m_pending = 0; m_stale = 0; mem_busy = 0;

        // ---- reset and first fetches, latency 2, decoder always ready
        vecs[0] = '{1, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0};
        vecs[1] = '{1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        vecs[2] = '{1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        vecs[3] = '{1, 1, 0, 32'h0, 1, 32'h4, 1, 32'h0};
        vecs[4] = '{1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        vecs[5] = '{1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        vecs[6] = '{1, 1, 0, 32'h0, 1, 32'h8, 1, 32'h4};
        vecs[7] = '{1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        vecs[8] = '{1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        vecs[9] = '{1, 1, 0, 32'h0, 1, 32'hC, 1, 32'h8};
        mem_lat = 2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(0, vecs[i].rdy, vecs[i].de, vecs[i].fl, vecs[i].fpc);
            chk("vec_req", {31'b0, s_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) chk("vec_addr", s_addr, vecs[i].e_addr);
            chk("vec_ifv", {31'b0, s_ifv}, {31'b0, vecs[i].e_ifv});
            if (vecs[i].e_ifv) begin
                chk("vec_ifpc", s_ifpc, vecs[i].e_ifpc);
                chk("vec_ifinst", s_ifinst, vecs[i].e_ifpc + 32'h13);
            end
        end

        // ---- queue fills with decoder stalled, then drains one per cycle
        do_reset();
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 0, 0, 32'h0);
            if (s_req) reqs++;
        end
        chk("full_req_count", 32'(reqs), 32'd8);
        chk("full_if_valid", {31'b0, s_ifv}, 32'h1);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 1, 0, 32'h0);
            chk("drain_valid", {31'b0, s_ifv}, 32'h1);
            chk("drain_pc", s_ifpc, 32'(i * 4));
            if (s_req && s_addr == 32'h20) found = 1;
        end
        chk("drain_resume_req", {31'b0, found}, 32'h1);

        // ---- flush while waiting: stale response must be dropped
        do_reset();
        cycle(0, 1, 0, 0, 32'h0);
        chk("stale_first_req", {31'b0, s_req}, 32'h1);
        cycle(0, 1, 0, 1, 32'h100);
        chk("stale_flush_noreq", {31'b0, s_req}, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'h0);
        chk("stale_not_queued", {31'b0, s_ifv}, 32'h0);
        chk("stale_redirect_req", {31'b0, s_req}, 32'h1);
        chk("stale_redirect_addr", s_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, 1, 0, 0, 32'h0);
            if (s_ifv) found = 1;
        end
        chk("stale_new_seen", {31'b0, found}, 32'h1);
        chk("stale_new_pc", s_ifpc, 32'h100);
        chk("stale_new_inst", s_ifinst, 32'h113);

        // ---- flush coinciding with response and pop
        do_reset();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            cycle(0, 1, 0, 0, 32'h0);
            if (mq.size() >= 2 && mem_busy && mem_wait == 0) found = 1;
        end
        chk("coin_setup", {31'b0, found}, 32'h1);
        cycle(0, 1, 1, 1, 32'h200);
        chk("coin_pop_valid", {31'b0, s_ifv}, 32'h1);
        chk("coin_no_req", {31'b0, s_req}, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
        chk("coin_empty", {31'b0, s_ifv}, 32'h0);
        chk("coin_req", {31'b0, s_req}, 32'h1);
        chk("coin_addr", s_addr, 32'h200);

        // ---- freeze mid-stream; popped PCs stay strictly sequential
        do_reset();
        exp_seq = 32'h0;
        for (int i = 0; i < 30; i++) begin
            if (i >= 8 && i < 13) begin
                cycle(0, 0, 1, 0, 32'h0);
                chk("freeze_no_req", {31'b0, s_req}, 32'h0);
            end else begin
                cycle(0, 1, 1, 0, 32'h0);
                if (s_ifv) begin
                    chk("seq_pc", s_ifpc, exp_seq);
                    exp_seq = exp_seq + 32'd4;
                end
            end
        end

        // ---- PC wrap-around past 32'hFFFFFFFC
        wrap_exp[0] = 32'hFFFFFFF8; wrap_exp[1] = 32'hFFFFFFFC; wrap_exp[2] = 32'h0;
        do_reset();
        cycle(0, 1, 1, 1, 32'hFFFFFFF8);
        reqs = 0;
        for (int i = 0; i < 30 && reqs < 3; i++) begin
            cycle(0, 1, 1, 0, 32'h0);
            if (s_req) begin got_addr[reqs] = s_addr; reqs++; end
        end
        chk("wrap_req_count", 32'(reqs), 32'd3);
        for (int i = 0; i < 3; i++) chk("wrap_addr", got_addr[i], wrap_exp[i]);

        // ---- JAL word at 32'h20
        special_addr = 32'h20; special_data = 32'h0100006F;
        do_reset();
        cycle(0, 1, 1, 1, 32'h20);
        chk("jal_flush_noreq", {31'b0, s_req}, 32'h0);
        reqs = 0;
        for (int i = 0; i < 30 && reqs < 2; i++) begin
            cycle(0, 1, 1, 0, 32'h0);
            if (s_req) begin got_addr[reqs] = s_addr; reqs++; end
        end
        chk("jal_req_count", 32'(reqs), 32'd2);
        chk("jal_first_addr", got_addr[0], 32'h20);
`ifdef IF_PREDECODE_JAL_EN
        chk("jal_next_addr", got_addr[1], 32'h30);
`else
        chk("jal_next_addr", got_addr[1], 32'h24);
`endif
        special_addr = 32'h1;

        // ---- randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_rdy, r_de, r_fl;
            mem_lat = $urandom_range(1, 4);
            r_rst = ($urandom_range(0, 199) == 0);
            r_rdy = ($urandom_range(0, 9) != 0);
            r_de  = ($urandom_range(0, 2) != 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            tmp   = $urandom;
            cycle(r_rst, r_rdy, r_de, r_fl, tmp & 32'hFFFFFFFC);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
